phase_seq_ctrl: RTL and testbench
=================================

Name: phase_seq_ctrl

Overview:
Parametrised one-hot phase sequencer driving a datapath through up to N_PHASE compute phases (READ, VECT, CROS, SORT, … generalised). It issues one command flag per phase, waits for that phase's done flag, and pulses a datapath counter reset on every phase completion. Successor to the fixed 8-phase controller, adding:
- runtime phase-enable (skip) mask
- programmable iteration limit with END state
- per-phase watchdog timeout with error capture
- start/abort handshake

Parameters:
N_PHASE, 8, number of phases; phase i drives cmd_flags[i] and waits on done_flags[i]; range 2..32
ITER_W, 8, width of iteration counter and max_iter
TMO_W, 16, width of watchdog counter and tmo_limit
PH_W, $clog2(N_PHASE), localparam, phase index width

Ports:
clk  in  1  clock, all state on rising edge
reset_n  in  1  asynchronous active-low reset
start  in  1  level; sampled in IDLE and END
abort  in  1  level; forces IDLE from any non-IDLE state
phase_en  in  N_PHASE  enabled-phase mask, latched on start
max_iter  in  ITER_W  iteration limit, latched on start; 0 = unlimited
tmo_limit  in  TMO_W  watchdog limit, latched on start; 0 = watchdog off
done_flags  in  N_PHASE  per-phase completion from datapath
cmd_flags  out  N_PHASE  one-hot command for the current phase, else 0
dp_cnt_rst  out  1  one-cycle datapath counter reset
busy  out  1  high in RUN
finished  out  1  sticky, high in END
timeout_err  out  1  sticky, high in ERR
err_phase  out  PH_W  phase index that timed out
iter_cnt  out  ITER_W  completed iterations

Behaviour:
- States: IDLE, RUN(phase p held in PH_W register), END, ERR.
- Reset (reset_n=0, async): IDLE, p=0, all outputs 0, latched config 0, watchdog 0.
- Combinational outputs decoded from registered state: cmd_flags=(1<<p) only in RUN; busy=RUN; finished=END; timeout_err=ERR.
- IDLE:
  - start=1 and phase_en!=0 -> next cycle RUN at lowest enabled phase; latch phase_en/max_iter/tmo_limit; iter_cnt<=0; watchdog<=0.
  - start=1 with phase_en==0: ignored, stay IDLE.
- RUN phase p:
  - Only done_flags[p] is observed; other bits ignored.
  - On done_flags[p]=1: dp_cnt_rst=1 same cycle (combinational). Next cycle, p <= next enabled phase above p; watchdog <= 0.
  - If no enabled phase above p (wrap): iter_cnt <= iter_cnt+1; p <= lowest enabled phase. If max_iter!=0 and iter_cnt+1==max_iter, go to END instead (iter_cnt still updated).
  - With max_iter=0, iter_cnt wraps modulo 2^ITER_W.
  - A single enabled phase re-enters itself every done: iter_cnt increments each time, dp_cnt_rst pulses each time.
  - Watchdog counts +1 per RUN cycle without done. If tmo_limit!=0 and watchdog==tmo_limit-1 with no done this cycle: dp_cnt_rst=1; next cycle ERR, err_phase<=p. Done in the same cycle wins over timeout.
  - Phase latency: cmd for phase p stays asserted until and including the done cycle; the next phase's cmd asserts the following cycle. There are no gap cycles.
- END: held until start (restarts exactly as from IDLE, relatching config) or abort (-> IDLE). iter_cnt is held.
- ERR: held until abort; start is ignored. err_phase is held.
- abort=1 in RUN/END/ERR: next cycle IDLE. dp_cnt_rst=1 in the abort cycle only if in RUN. iter_cnt and err_phase are held until the next start. abort has priority over done, timeout and start.
- abort in IDLE: no effect (start is ignored that cycle).
- The state register is never illegal. If the decode sees an out-of-range p (p>=N_PHASE), it returns to IDLE next cycle.

Test Plan:
- Reset mid-RUN: assert reset_n=0 at phase 3 -> all outputs 0 immediately (async); after release, IDLE with cmd_flags=0.
- phase_en=8'hFF, max_iter=2, tmo_limit=0, done pulsed 1 cycle after each cmd -> cmd_flags 01,02,…,80 twice, 16 dp_cnt_rst pulses, iter_cnt=2, finished=1, busy=0.
- phase_en=8'b1010_0101, max_iter=1 -> cmd sequence 01,04,20,80 then END; skipped phases never asserted.
- tmo_limit=10, done withheld at phase 2 -> dp_cnt_rst pulse on 10th RUN cycle of phase 2, ERR, timeout_err=1, err_phase=2; start ignored; abort -> IDLE.
- done_flags[p] arriving in the exact timeout cycle -> advance, no ERR. Abort in the same cycle as a done -> IDLE, iter_cnt unchanged.
- phase_en=8'h10, max_iter=0, 300 dones -> cmd_flags stays 10, iter_cnt wraps to 44 (300 mod 256), finished stays 0.

Source files
------------

// File: rtl/phase_seq_ctrl.sv
// One-hot phase sequencer: issues a command per enabled phase, waits for its done flag,
// counts iterations up to a programmable limit and traps per-phase watchdog timeouts.
module phase_seq_ctrl #(
  parameter int unsigned N_PHASE = 8,
  parameter int unsigned ITER_W  = 8,
  parameter int unsigned TMO_W   = 16,
  localparam int unsigned PH_W   = $clog2(N_PHASE)
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               start,
  input  logic               abort,
  input  logic [N_PHASE-1:0] phase_en,
  input  logic [ITER_W-1:0]  max_iter,
  input  logic [TMO_W-1:0]   tmo_limit,
  input  logic [N_PHASE-1:0] done_flags,
  output logic [N_PHASE-1:0] cmd_flags,
  output logic               dp_cnt_rst,
  output logic               busy,
  output logic               finished,
  output logic               timeout_err,
  output logic [PH_W-1:0]    err_phase,
  output logic [ITER_W-1:0]  iter_cnt
);

  typedef enum logic [1:0] {StIdle, StRun, StEnd, StErr} state_e;

  state_e             state_q, state_d;
  logic [PH_W-1:0]    p_q, p_d;
  logic [PH_W-1:0]    err_phase_q, err_phase_d;
  logic [N_PHASE-1:0] en_q, en_d;
  logic [ITER_W-1:0]  max_q, max_d;
  logic [ITER_W-1:0]  iter_q, iter_d;
  logic [TMO_W-1:0]   tmo_q, tmo_d;
  logic [TMO_W-1:0]   wd_q, wd_d;

  logic [PH_W-1:0]    low_in, low_cfg, nxt_en;
  logic               nxt_found;
  logic [PH_W:0]      p_ext;
  logic               p_oob, done_p, tmo_hit, start_ok;
  logic [ITER_W-1:0]  iter_inc;

  // Priority scan: lowest set bit of the live and latched masks, and next enabled above p.
  always_comb begin
    low_in    = '0;
    low_cfg   = '0;
    nxt_en    = '0;
    nxt_found = 1'b0;
    for (int i = N_PHASE - 1; i >= 0; i--) begin
      if (phase_en[i]) low_in = PH_W'(i);
      if (en_q[i]) low_cfg = PH_W'(i);
      if (en_q[i] && (i > int'(p_q))) begin
        nxt_en    = PH_W'(i);
        nxt_found = 1'b1;
      end
    end
  end

  always_comb begin
    p_ext    = {1'b0, p_q};
    p_oob    = (p_ext >= (PH_W + 1)'(N_PHASE));
    done_p   = !p_oob && done_flags[p_q];
    tmo_hit  = !p_oob && !done_p && (tmo_q != '0) && (wd_q == tmo_q - 1'b1);
    start_ok = start && (phase_en != '0);
    iter_inc = iter_q + 1'b1;
  end

  always_comb begin
    state_d     = state_q;
    p_d         = p_q;
    err_phase_d = err_phase_q;
    en_d        = en_q;
    max_d       = max_q;
    iter_d      = iter_q;
    tmo_d       = tmo_q;
    wd_d        = wd_q;
    if (abort) begin
      if (state_q != StIdle) state_d = StIdle;
    end else begin
      unique case (state_q)
        StIdle, StEnd: begin
          if (start_ok) begin
            state_d     = StRun;
            p_d         = low_in;
            en_d        = phase_en;
            max_d       = max_iter;
            tmo_d       = tmo_limit;
            iter_d      = '0;
            wd_d        = '0;
            err_phase_d = '0;
          end
        end
        StRun: begin
          if (p_oob) begin
            state_d = StIdle;
          end else if (done_p) begin
            wd_d = '0;
            if (nxt_found) begin
              p_d = nxt_en;
            end else begin
              iter_d = iter_inc;
              if ((max_q != '0) && (iter_inc == max_q)) state_d = StEnd;
              else p_d = low_cfg;
            end
          end else if (tmo_hit) begin
            state_d     = StErr;
            err_phase_d = p_q;
          end else begin
            wd_d = wd_q + 1'b1;
          end
        end
        StErr: begin
        end
        default: state_d = StIdle;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= StIdle;
      p_q         <= '0;
      err_phase_q <= '0;
      en_q        <= '0;
      max_q       <= '0;
      iter_q      <= '0;
      tmo_q       <= '0;
      wd_q        <= '0;
    end else begin
      state_q     <= state_d;
      p_q         <= p_d;
      err_phase_q <= err_phase_d;
      en_q        <= en_d;
      max_q       <= max_d;
      iter_q      <= iter_d;
      tmo_q       <= tmo_d;
      wd_q        <= wd_d;
    end
  end

  always_comb begin
    cmd_flags   = (state_q == StRun && !p_oob) ? (N_PHASE'(1) << p_q) : '0;
    dp_cnt_rst  = (state_q == StRun) && (abort || done_p || tmo_hit);
    busy        = (state_q == StRun);
    finished    = (state_q == StEnd);
    timeout_err = (state_q == StErr);
    err_phase   = err_phase_q;
    iter_cnt    = iter_q;
  end

endmodule

// File: tb/tb_phase_seq_ctrl.sv
// Randomized and directed bench for phase_seq_ctrl; expected command sequences come from
// a list model built directly from the enable mask and iteration limit.
module tb_phase_seq_ctrl;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        start = 1'b0;
  logic        abort = 1'b0;
  logic [7:0]  phase_en = '0;
  logic [7:0]  max_iter = '0;
  logic [15:0] tmo_limit = '0;
  logic [7:0]  done_flags = '0;
  logic [7:0]  cmd_flags;
  logic        dp_cnt_rst, busy, finished, timeout_err;
  logic [2:0]  err_phase;
  logic [7:0]  iter_cnt;

  int checks = 0;
  int failures = 0;
  logic [7:0] obs_q[$];
  logic [7:0] exp_q[$];
  int dp_seen;

  phase_seq_ctrl #(.N_PHASE(8), .ITER_W(8), .TMO_W(16)) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .start      (start),
    .abort      (abort),
    .phase_en   (phase_en),
    .max_iter   (max_iter),
    .tmo_limit  (tmo_limit),
    .done_flags (done_flags),
    .cmd_flags  (cmd_flags),
    .dp_cnt_rst (dp_cnt_rst),
    .busy       (busy),
    .finished   (finished),
    .timeout_err(timeout_err),
    .err_phase  (err_phase),
    .iter_cnt   (iter_cnt)
  );

  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL global_timeout sim did not finish");
    $fatal(1);
  end

  // Enabled phases in ascending order, repeated once per iteration.
  function automatic void build_expected(input logic [7:0] en, input int iters);
    exp_q.delete();
    for (int it = 0; it < iters; it++)
      for (int i = 0; i < 8; i++)
        if (en[i]) exp_q.push_back(8'h01 << i);
  endfunction

  // Starts a run and answers each command after a random delay, recording the command
  // being acknowledged and every dp_cnt_rst pulse seen.
  task automatic run_seq(input logic [7:0] en, input logic [7:0] mi, input int dmin,
                         input int dmax, input bit noise, input int max_dones, output bit hung);
    int wait_cnt;
    int dones;
    obs_q.delete();
    dp_seen = 0;
    dones = 0;
    hung = 1'b1;
    @(negedge clk);
    phase_en = en; max_iter = mi; tmo_limit = '0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_cnt = $urandom_range(dmax, dmin);
    for (int cyc = 0; cyc < 5000; cyc++) begin
      if (!busy || (max_dones > 0 && dones == max_dones)) begin
        hung = 1'b0;
        break;
      end
      done_flags = noise ? (8'($urandom) & ~cmd_flags) : 8'h00;
      if (wait_cnt == 0) begin
        done_flags = done_flags | cmd_flags;
        obs_q.push_back(cmd_flags);
        dones++;
        wait_cnt = $urandom_range(dmax, dmin);
      end else begin
        wait_cnt--;
      end
      #1;
      if (dp_cnt_rst) dp_seen++;
      @(negedge clk);
    end
    done_flags = '0;
  endtask

  task automatic test_reset();
    repeat (2) @(negedge clk);
    checks++;
    if ({cmd_flags, dp_cnt_rst, busy, finished, timeout_err, err_phase, iter_cnt} !== '0) begin
      failures++;
      $display("FAIL reset_outputs got=%h exp=0",
               {cmd_flags, dp_cnt_rst, busy, finished, timeout_err, err_phase, iter_cnt});
    end
    reset_n = 1'b1;
    @(negedge clk);
    checks++;
    if (busy !== 1'b0 || cmd_flags !== 8'h00) begin
      failures++;
      $display("FAIL reset_release busy=%b cmd=%h exp busy=0 cmd=00", busy, cmd_flags);
    end
  endtask

  task automatic test_start_ignored();
    phase_en = 8'h00; start = 1'b1;
    @(negedge clk);
    checks++;
    if (busy !== 1'b0) begin
      failures++;
      $display("FAIL start_empty_mask busy=%b exp=0", busy);
    end
    phase_en = 8'hFF; abort = 1'b1;
    @(negedge clk);
    start = 1'b0; abort = 1'b0;
    checks++;
    if (busy !== 1'b0) begin
      failures++;
      $display("FAIL start_with_abort_idle busy=%b exp=0", busy);
    end
  endtask

  task automatic test_full_sweep();
    bit hung;
    bit ok;
    run_seq(8'hFF, 8'd2, 1, 1, 1'b0, 0, hung);
    build_expected(8'hFF, 2);
    ok = !hung && (obs_q.size() == exp_q.size());
    if (ok) foreach (exp_q[i]) if (obs_q[i] !== exp_q[i]) ok = 1'b0;
    checks++;
    if (!ok) begin
      failures++;
      $display("FAIL sweep_sequence got_len=%0d exp_len=%0d hung=%0b",
               obs_q.size(), exp_q.size(), hung);
    end
    checks++;
    if (dp_seen != 16) begin
      failures++;
      $display("FAIL sweep_dp_pulses got=%0d exp=16", dp_seen);
    end
    checks++;
    if (iter_cnt !== 8'd2 || finished !== 1'b1 || busy !== 1'b0) begin
      failures++;
      $display("FAIL sweep_end iter=%0d fin=%b busy=%b exp iter=2 fin=1 busy=0",
               iter_cnt, finished, busy);
    end
  endtask

  task automatic test_skip();
    bit hung;
    bit ok;
    run_seq(8'hA5, 8'd1, 0, 2, 1'b1, 0, hung);
    build_expected(8'hA5, 1);
    ok = !hung && (obs_q.size() == exp_q.size());
    if (ok) foreach (exp_q[i]) if (obs_q[i] !== exp_q[i]) ok = 1'b0;
    checks++;
    if (!ok) begin
      failures++;
      $display("FAIL skip_sequence got_len=%0d exp_len=4 hung=%0b", obs_q.size(), hung);
    end
    checks++;
    if (finished !== 1'b1 || iter_cnt !== 8'd1) begin
      failures++;
      $display("FAIL skip_end fin=%b iter=%0d exp fin=1 iter=1", finished, iter_cnt);
    end
  endtask

  task automatic test_random();
    bit hung;
    bit ok;
    logic [7:0] en;
    logic [7:0] mi;
    for (int t = 0; t < 8; t++) begin
      en = 8'($urandom_range(255, 1));
      mi = 8'($urandom_range(3, 1));
      run_seq(en, mi, 0, 3, 1'b1, 0, hung);
      build_expected(en, int'(mi));
      ok = !hung && (obs_q.size() == exp_q.size());
      if (ok) foreach (exp_q[i]) if (obs_q[i] !== exp_q[i]) ok = 1'b0;
      checks++;
      if (!ok) begin
        failures++;
        $display("FAIL rand_seq en=%h mi=%0d got_len=%0d exp_len=%0d hung=%0b",
                 en, mi, obs_q.size(), exp_q.size(), hung);
      end
      checks++;
      if (dp_seen != exp_q.size() || iter_cnt !== mi || finished !== 1'b1) begin
        failures++;
        $display("FAIL rand_end en=%h dp=%0d iter=%0d fin=%b exp dp=%0d iter=%0d fin=1",
                 en, dp_seen, iter_cnt, finished, exp_q.size(), mi);
      end
    end
  endtask

  task automatic test_timeout();
    int bad_dp;
    bad_dp = 0;
    @(negedge clk);
    phase_en = 8'hFF; max_iter = 8'd0; tmo_limit = 16'd10; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    done_flags = 8'h01;
    @(negedge clk);
    done_flags = 8'h02;
    @(negedge clk);
    done_flags = 8'h00;
    for (int k = 1; k <= 10; k++) begin
      #1;
      if (dp_cnt_rst !== (k == 10) || cmd_flags !== 8'h04) bad_dp++;
      @(negedge clk);
    end
    checks++;
    if (bad_dp != 0) begin
      failures++;
      $display("FAIL tmo_pulse_timing bad_cycles=%0d exp=0", bad_dp);
    end
    checks++;
    if (timeout_err !== 1'b1 || err_phase !== 3'd2 || busy !== 1'b0 || cmd_flags !== 8'h00) begin
      failures++;
      $display("FAIL tmo_err err=%b ph=%0d busy=%b cmd=%h exp err=1 ph=2 busy=0 cmd=00",
               timeout_err, err_phase, busy, cmd_flags);
    end
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    checks++;
    if (timeout_err !== 1'b1 || busy !== 1'b0) begin
      failures++;
      $display("FAIL tmo_start_ignored err=%b busy=%b exp err=1 busy=0", timeout_err, busy);
    end
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    checks++;
    if (timeout_err !== 1'b0 || busy !== 1'b0 || err_phase !== 3'd2) begin
      failures++;
      $display("FAIL tmo_abort err=%b busy=%b ph=%0d exp err=0 busy=0 ph=2",
               timeout_err, busy, err_phase);
    end
  endtask

  task automatic test_done_at_timeout_and_abort();
    phase_en = 8'h03; max_iter = 8'd0; tmo_limit = 16'd5; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (4) @(negedge clk);
    done_flags = 8'h01;
    #1;
    checks++;
    if (dp_cnt_rst !== 1'b1) begin
      failures++;
      $display("FAIL race_dp got=%b exp=1", dp_cnt_rst);
    end
    @(negedge clk);
    checks++;
    if (cmd_flags !== 8'h02 || timeout_err !== 1'b0) begin
      failures++;
      $display("FAIL race_advance cmd=%h err=%b exp cmd=02 err=0", cmd_flags, timeout_err);
    end
    done_flags = 8'h02;
    @(negedge clk);
    done_flags = 8'h01;
    @(negedge clk);
    done_flags = 8'h02; abort = 1'b1;
    #1;
    checks++;
    if (dp_cnt_rst !== 1'b1 || iter_cnt !== 8'd1) begin
      failures++;
      $display("FAIL abort_cycle dp=%b iter=%0d exp dp=1 iter=1", dp_cnt_rst, iter_cnt);
    end
    @(negedge clk);
    done_flags = 8'h00; abort = 1'b0;
    checks++;
    if (busy !== 1'b0 || iter_cnt !== 8'd1 || finished !== 1'b0) begin
      failures++;
      $display("FAIL abort_vs_done busy=%b iter=%0d fin=%b exp busy=0 iter=1 fin=0",
               busy, iter_cnt, finished);
    end
  endtask

  task automatic test_single_phase_wrap();
    bit hung;
    bit ok;
    run_seq(8'h10, 8'd0, 0, 0, 1'b1, 300, hung);
    ok = !hung && (obs_q.size() == 300);
    if (ok) foreach (obs_q[i]) if (obs_q[i] !== 8'h10) ok = 1'b0;
    checks++;
    if (!ok) begin
      failures++;
      $display("FAIL wrap_cmds got_len=%0d exp_len=300 hung=%0b", obs_q.size(), hung);
    end
    checks++;
    if (iter_cnt !== 8'(300 % 256) || finished !== 1'b0 || busy !== 1'b1 || dp_seen != 300) begin
      failures++;
      $display("FAIL wrap_state iter=%0d fin=%b busy=%b dp=%0d exp iter=44 fin=0 busy=1 dp=300",
               iter_cnt, finished, busy, dp_seen);
    end
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    checks++;
    if (busy !== 1'b0 || iter_cnt !== 8'd44) begin
      failures++;
      $display("FAIL wrap_abort busy=%b iter=%0d exp busy=0 iter=44", busy, iter_cnt);
    end
  endtask

  task automatic test_reset_mid_run();
    phase_en = 8'hFF; max_iter = 8'd0; tmo_limit = 16'd0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int k = 0; k < 3; k++) begin
      done_flags = cmd_flags;
      @(negedge clk);
    end
    done_flags = 8'h00;
    checks++;
    if (cmd_flags !== 8'h08) begin
      failures++;
      $display("FAIL midrun_phase3 cmd=%h exp=08", cmd_flags);
    end
    #2;
    reset_n = 1'b0;
    #1;
    checks++;
    if ({cmd_flags, dp_cnt_rst, busy, finished, timeout_err, err_phase, iter_cnt} !== '0) begin
      failures++;
      $display("FAIL midrun_async_reset got=%h exp=0",
               {cmd_flags, dp_cnt_rst, busy, finished, timeout_err, err_phase, iter_cnt});
    end
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    checks++;
    if (busy !== 1'b0 || cmd_flags !== 8'h00) begin
      failures++;
      $display("FAIL midrun_after_reset busy=%b cmd=%h exp busy=0 cmd=00", busy, cmd_flags);
    end
  endtask

  initial begin
    test_reset();
    test_start_ignored();
    test_full_sweep();
    test_skip();
    test_random();
    test_timeout();
    test_done_at_timeout_and_abort();
    test_single_phase_wrap();
    test_reset_mid_run();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
